// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
// Module : ntt_pkg
// Brief  : Shared constants, FSM encoding and modular add/sub helpers for the
//          NTT butterfly stage.
// Rev    : 1.0  initial release
// ============================================================================
package ntt_pkg;

  localparam int C_DEF_N_BITS   = 25;
  localparam int C_DEF_MOD      = 17;
  localparam int C_DEF_LOGN     = 3;
  localparam int C_DEF_ROOT     = 2;
  localparam int C_DEF_ROOT_INV = 9;

  localparam int C_ARITH_W = 64;

  localparam logic [1:0] C_ST_IDLE    = 2'd0;
  localparam logic [1:0] C_ST_TW_CALC = 2'd1;
  localparam logic [1:0] C_ST_BFLY    = 2'd2;
  localparam logic [1:0] C_ST_DONE    = 2'd3;

  typedef logic [C_ARITH_W-1:0] arith_t;

  // Operands are expected to be < m; one conditional correction suffices.
  function automatic arith_t mod_add(input arith_t a, input arith_t b, input arith_t m);
    logic [C_ARITH_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) begin
      s = s - {1'b0, m};
    end
    return s[C_ARITH_W-1:0];
  endfunction

  function automatic arith_t mod_sub(input arith_t a, input arith_t b, input arith_t m);
    logic [C_ARITH_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[C_ARITH_W]) begin
      d = d + {1'b0, m};
    end
    return d[C_ARITH_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_bfly_stage_if.sv
`default_nettype none
// ============================================================================
// Module : ntt_bfly_stage_if
// Brief  : Request/response handshake bundle for the NTT butterfly stage.
// Rev    : 1.0  initial release
// ============================================================================
interface ntt_bfly_stage_if
  import ntt_pkg::*;
#(
  parameter int N_BITS = C_DEF_N_BITS
);

  logic              in_valid;
  logic              in_ready;
  logic [N_BITS-1:0] u_inp;
  logic [N_BITS-1:0] v_inp;
  logic [4:0]        i;
  logic [4:0]        j;
  logic              inv;
  logic              out_valid;
  logic              out_ready;
  logic [N_BITS-1:0] x1_out;
  logic [N_BITS-1:0] x2_out;
  logic [N_BITS-1:0] tw_out;

  modport master (
    output in_valid, u_inp, v_inp, i, j, inv, out_ready,
    input  in_ready, out_valid, x1_out, x2_out, tw_out
  );

  modport slave (
    input  in_valid, u_inp, v_inp, i, j, inv, out_ready,
    output in_ready, out_valid, x1_out, x2_out, tw_out
  );

endinterface
`default_nettype wire

// File: rtl/mod_mul.sv
`default_nettype none
// ============================================================================
// Module : mod_mul
// Brief  : Combinational modular multiplier, (a * b) mod MOD.
// Rev    : 1.0  initial release
// ============================================================================
module mod_mul #(
  parameter int          N_BITS = 25,
  parameter int unsigned MOD    = 17
) (
  input  logic [N_BITS-1:0] i_a,
  input  logic [N_BITS-1:0] i_b,
  output logic [N_BITS-1:0] o_p
);

  localparam logic [2*N_BITS-1:0] C_MOD_W = (2*N_BITS)'(MOD);

  logic [2*N_BITS-1:0] w_prod;

  // Full double-width product so nothing is lost before the reduction.
  assign w_prod = {{N_BITS{1'b0}}, i_a} * {{N_BITS{1'b0}}, i_b};
  assign o_p    = N_BITS'(w_prod % C_MOD_W);

endmodule
`default_nettype wire

// File: rtl/ntt_bfly_stage.sv
`default_nettype none
// ============================================================================
// Module : ntt_bfly_stage
// Brief  : Radix-2 NTT butterfly with on-the-fly twiddle generation and a
//          single-entry twiddle cache.
// Rev    : 1.0  initial release
// ============================================================================
module ntt_bfly_stage
  import ntt_pkg::*;
#(
  parameter int          N_BITS   = C_DEF_N_BITS,
  parameter int unsigned MOD      = C_DEF_MOD,
  parameter int          LOGN     = C_DEF_LOGN,
  parameter int          ROOT     = C_DEF_ROOT,
  parameter int          ROOT_INV = C_DEF_ROOT_INV
) (
  input  logic            clock,
  input  logic            reset_n,
  ntt_bfly_stage_if.slave bus
);

  localparam int C_EW = LOGN - 1;
  localparam int C_CW = (C_EW > 1) ? $clog2(C_EW) : 1;

  localparam logic [N_BITS-1:0] C_ONE       = N_BITS'(1);
  localparam logic [N_BITS-1:0] C_ROOT      = N_BITS'(ROOT);
  localparam logic [N_BITS-1:0] C_ROOT_INV  = N_BITS'(ROOT_INV);
  localparam logic [C_CW-1:0]   C_CNT_START = C_CW'(C_EW - 1);
  localparam logic [C_CW-1:0]   C_CNT_ONE   = C_CW'(1);

  logic [1:0]        r_state;
  logic [N_BITS-1:0] r_u;
  logic [N_BITS-1:0] r_v;
  logic [C_EW-1:0]   r_e;
  logic              r_inv;
  logic [N_BITS-1:0] r_acc;
  logic [C_CW-1:0]   r_cnt;

  logic              r_cache_valid;
  logic [C_EW-1:0]   r_cache_e;
  logic              r_cache_inv;
  logic [N_BITS-1:0] r_cache_w;

  logic [N_BITS-1:0] r_x1;
  logic [N_BITS-1:0] r_x2;
  logic [N_BITS-1:0] r_tw;
  logic              r_out_valid;

  logic [4:0]        w_ic;
  logic [C_EW-1:0]   w_e;
  logic              w_hit;
  logic [N_BITS-1:0] w_sq;
  logic [N_BITS-1:0] w_mul_b;
  logic [N_BITS-1:0] w_step;
  logic [N_BITS-1:0] w_t;
  logic [N_BITS-1:0] w_x1;
  logic [N_BITS-1:0] w_x2;

  // Exponent: j masked to ic bits, shifted up by (LOGN-1-ic).
  assign w_ic = (bus.i > 5'(C_EW)) ? 5'(C_EW) : bus.i;

  always_comb begin
    w_e = '0;
    for (int b = 0; b < C_EW; b++) begin
      for (int s = 0; s < 5; s++) begin
        if ((s < int'(w_ic)) && ((s + C_EW - int'(w_ic)) == b)) begin
          w_e[b] = bus.j[s];
        end
      end
    end
  end

  assign w_hit = r_cache_valid && (w_e == r_cache_e) && (bus.inv == r_cache_inv);

  // Square-and-multiply step, MSB of the exponent first.
  assign w_mul_b = r_e[r_cnt] ? (r_inv ? C_ROOT_INV : C_ROOT) : C_ONE;

  mod_mul #(.N_BITS(N_BITS), .MOD(MOD)) u_mul_sq (
    .i_a (r_acc),
    .i_b (r_acc),
    .o_p (w_sq)
  );

  mod_mul #(.N_BITS(N_BITS), .MOD(MOD)) u_mul_step (
    .i_a (w_sq),
    .i_b (w_mul_b),
    .o_p (w_step)
  );

  mod_mul #(.N_BITS(N_BITS), .MOD(MOD)) u_mul_bfly (
    .i_a (r_acc),
    .i_b (r_v),
    .o_p (w_t)
  );

  assign w_x1 = N_BITS'(mod_add(arith_t'(r_u), arith_t'(w_t), arith_t'(MOD)));
  assign w_x2 = N_BITS'(mod_sub(arith_t'(r_u), arith_t'(w_t), arith_t'(MOD)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= C_ST_IDLE;
      r_u           <= '0;
      r_v           <= '0;
      r_e           <= '0;
      r_inv         <= 1'b0;
      r_acc         <= C_ONE;
      r_cnt         <= '0;
      r_cache_valid <= 1'b0;
      r_cache_e     <= '0;
      r_cache_inv   <= 1'b0;
      r_cache_w     <= C_ONE;
      r_x1          <= '0;
      r_x2          <= '0;
      r_tw          <= C_ONE;
      r_out_valid   <= 1'b0;
    end else begin
      case (r_state)
        C_ST_IDLE: begin
          if (bus.in_valid) begin
            r_u   <= bus.u_inp;
            r_v   <= bus.v_inp;
            r_e   <= w_e;
            r_inv <= bus.inv;
            if (w_e == '0) begin
              r_acc   <= C_ONE;
              r_state <= C_ST_BFLY;
            end else if (w_hit) begin
              r_acc   <= r_cache_w;
              r_state <= C_ST_BFLY;
            end else begin
              r_acc   <= C_ONE;
              r_cnt   <= C_CNT_START;
              r_state <= C_ST_TW_CALC;
            end
          end
        end
        C_ST_TW_CALC: begin
          r_acc <= w_step;
          if (r_cnt == '0) begin
            r_cache_valid <= 1'b1;
            r_cache_e     <= r_e;
            r_cache_inv   <= r_inv;
            r_cache_w     <= w_step;
            r_state       <= C_ST_BFLY;
          end else begin
            r_cnt <= r_cnt - C_CNT_ONE;
          end
        end
        C_ST_BFLY: begin
          r_x1        <= w_x1;
          r_x2        <= w_x2;
          r_tw        <= r_acc;
          r_out_valid <= 1'b1;
          r_state     <= C_ST_DONE;
        end
        C_ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= C_ST_IDLE;
          end
        end
        default: begin
          r_state <= C_ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == C_ST_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.x1_out    = r_x1;
  assign bus.x2_out    = r_x2;
  assign bus.tw_out    = r_tw;

endmodule
`default_nettype wire

// File: tb/tb_ntt_bfly_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_ntt_bfly_stage
// Brief  : Randomised self-checking bench for ntt_bfly_stage against a
//          behavioural twiddle/butterfly model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ntt_bfly_stage;
  import ntt_pkg::*;

  localparam int NB       = 25;
  localparam int MODV     = 17;
  localparam int LOGN     = 3;
  localparam int ROOT     = 2;
  localparam int ROOT_INV = 9;
  localparam int TMO      = 100;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  ntt_bfly_stage_if #(.N_BITS(NB)) bus ();

  ntt_bfly_stage #(
    .N_BITS   (NB),
    .MOD      (MODV),
    .LOGN     (LOGN),
    .ROOT     (ROOT),
    .ROOT_INV (ROOT_INV)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int x1;
    int x2;
    int tw;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model of the single-entry twiddle cache (only to predict latency).
  bit   m_cv = 1'b0;
  int   m_ce = 0;
  bit   m_ci = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int model_exp(input int ii, input int jj);
    int ic;
    ic = (ii < LOGN - 1) ? ii : LOGN - 1;
    return (jj & ((1 << ic) - 1)) << (LOGN - 1 - ic);
  endfunction

  function automatic int model_pow(input int r, input int e);
    longint w;
    w = 1;
    for (int k = 0; k < e; k++) w = (w * r) % MODV;
    return int'(w);
  endfunction

  // Compare process: every cycle a result is presented it must match the head.
  always @(negedge clock) begin
    if (reset_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out_valid: got 1, expected 0 (t=%0t)", $time);
      end else begin
        check("x1_out", 64'(bus.x1_out), 64'(exp_q[0].x1));
        check("x2_out", 64'(bus.x2_out), 64'(exp_q[0].x2));
        check("tw_out", 64'(bus.tw_out), 64'(exp_q[0].tw));
        check("in_ready_busy", 64'(bus.in_ready), 64'd0);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Pinned values (ptw < 0 means no pin) check the model itself.
  task automatic issue(input int ii, input int jj, input int uu, input int vv, input bit iv,
                       input int px1, input int px2, input int ptw, input int plat,
                       output int lat_exp);
    int  e, w, t, n;
    bit  hit;
    exp_t x;
    e   = model_exp(ii, jj);
    w   = model_pow(iv ? ROOT_INV : ROOT, e);
    t   = int'((longint'(w) * vv) % MODV);
    hit = (e == 0) || (m_cv && m_ce == e && m_ci == iv);
    if (!hit) begin
      m_cv = 1'b1;
      m_ce = e;
      m_ci = iv;
    end
    lat_exp = hit ? 2 : 2 + (LOGN - 1);
    x.x1 = (uu + t) % MODV;
    x.x2 = (uu - t + MODV) % MODV;
    x.tw = w;
    if (ptw >= 0) begin
      check("model_x1", 64'(x.x1), 64'(px1));
      check("model_x2", 64'(x.x2), 64'(px2));
      check("model_tw", 64'(x.tw), 64'(ptw));
      check("model_lat", 64'(lat_exp), 64'(plat));
    end
    exp_q.push_back(x);
    n = 0;
    while (!bus.in_ready && n < TMO) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0, expected 1 (t=%0t)", $time);
    end
    bus.in_valid = 1'b1;
    bus.i        = 5'(ii);
    bus.j        = 5'(jj);
    bus.u_inp    = NB'(uu);
    bus.v_inp    = NB'(vv);
    bus.inv      = iv;
    @(posedge clock);
    #1;
    // Keep in_valid high with junk while busy; the block must ignore it.
    bus.u_inp = NB'($urandom_range(0, MODV - 1));
    bus.v_inp = NB'($urandom_range(0, MODV - 1));
    bus.i     = 5'($urandom_range(0, 31));
    bus.j     = 5'($urandom_range(0, 31));
    bus.inv   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result(input int lat_exp, input int stall);
    int edges;
    edges = 1;
    while (!bus.out_valid && edges < TMO) begin
      @(posedge clock);
      #1;
      edges++;
    end
    check("latency", 64'(edges), 64'(lat_exp));
    if (!bus.out_valid) begin
      bus.in_valid = 1'b0;
      return;
    end
    if (stall > 0) begin
      bus.out_ready = 1'b0;
      repeat (stall) begin
        @(posedge clock);
        #1;
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    check("in_ready_after", 64'(bus.in_ready), 64'd1);
    check("out_valid_after", 64'(bus.out_valid), 64'd0);
  endtask

  task automatic run(input int ii, input int jj, input int uu, input int vv, input bit iv,
                     input int px1, input int px2, input int ptw, input int plat, input int stall);
    int lat;
    issue(ii, jj, uu, vv, iv, px1, px2, ptw, plat, lat);
    wait_result(lat, stall);
  endtask

  initial begin
    int lat;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.u_inp     = '0;
    bus.v_inp     = '0;
    bus.i         = '0;
    bus.j         = '0;
    bus.inv       = 1'b0;

    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_x1", 64'(bus.x1_out), 64'd0);
    check("rst_x2", 64'(bus.x2_out), 64'd0);
    check("rst_tw", 64'(bus.tw_out), 64'd1);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    run(0, 0, 3, 5, 1'b0, 8, 15, 1, 2, 0);
    run(2, 1, 3, 5, 1'b0, 13, 10, 2, 4, 0);
    run(2, 3, 1, 16, 1'b0, 10, 9, 8, 4, 0);
    run(2, 3, 1, 16, 1'b0, 10, 9, 8, 2, 0);
    run(2, 1, 3, 5, 1'b1, 14, 9, 9, 4, 0);
    // Backpressure; also leaves (e=3, forward) in the cache.
    run(2, 3, 1, 16, 1'b0, 10, 9, 8, 4, 5);

    // Reset in the middle of twiddle generation.
    issue(2, 2, 7, 4, 1'b0, -1, -1, -1, -1, lat);
    @(posedge clock);
    #1;
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    m_cv = 1'b0;
    #1;
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_x1", 64'(bus.x1_out), 64'd0);
    check("arst_x2", 64'(bus.x2_out), 64'd0);
    check("arst_tw", 64'(bus.tw_out), 64'd1);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    run(2, 3, 1, 16, 1'b0, 10, 9, 8, 4, 0);

    for (int n = 0; n < 60; n++) begin
      run($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, MODV - 1),
          $urandom_range(0, MODV - 1), 1'($urandom_range(0, 1)), -1, -1, -1, -1,
          $urandom_range(0, 3));
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
